// File: rtl/invsqrt_nr_ctrl.sv
// Fast inverse-square-root sequencer: magic-constant seed followed by ITERS
// Newton-Raphson steps issued one at a time to a shared external FP unit.
module invsqrt_nr_ctrl #(
  parameter int unsigned ITERS        = 1,
  parameter logic [31:0] MAGIC        = 32'h5f3759df,
  parameter logic [31:0] THREE_HALVES = 32'h3FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_special,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_sel,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        res_valid,
  input  logic [31:0] res_data
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_SQ_I,
    ST_SQ_W,
    ST_HALF_I,
    ST_HALF_W,
    ST_SUB_I,
    ST_SUB_W,
    ST_UPD_I,
    ST_UPD_W,
    ST_DONE
  } state_t;

  localparam logic [1:0] LP_ITERS = 2'(ITERS);

  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_t;
  logic [31:0] r_half;
  logic [1:0]  r_iter;
  logic        r_special;

  logic [7:0]  w_exp;
  logic        w_zero;
  logic        w_inf_nan;
  logic        w_nan;
  logic        w_spec;
  logic [31:0] w_spec_val;
  logic [31:0] w_half;
  logic        w_last;
  logic        w_accept;

  assign w_exp     = r_x[30:23];
  assign w_zero    = (w_exp == '0);
  assign w_inf_nan = (w_exp == '1);
  assign w_nan     = w_inf_nan && (r_x[22:0] != '0);
  assign w_spec    = w_zero || r_x[31] || w_inf_nan;

  // Zero/denormal is tested first so that -0 yields +Inf rather than NaN.
  always_comb begin
    w_spec_val = '0;
    if (w_zero)
      w_spec_val = 32'h7F800000;
    else if (w_nan || r_x[31])
      w_spec_val = 32'h7FC00000;
  end

  // exp==1 halves into the denormal range by shifting the implicit one in.
  assign w_half = (w_exp == 8'd1) ? {1'b0, 8'd0, 1'b1, r_x[22:1]}
                                  : {1'b0, w_exp - 8'd1, r_x[22:0]};

  assign w_last   = (r_iter == LP_ITERS - 2'd1);
  assign w_accept = r_in_ready && in_valid;

  always_comb begin
    w_next   = r_state;
    op_valid = 1'b0;
    op_sel   = 1'b0;
    op_a     = '0;
    op_b     = '0;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_INIT;
      ST_INIT:   w_next = w_spec ? ST_DONE : ST_SQ_I;
      ST_SQ_I: begin
        op_valid = 1'b1;
        op_a     = r_y;
        op_b     = r_y;
        if (op_ready) w_next = ST_SQ_W;
      end
      ST_SQ_W:   if (res_valid) w_next = ST_HALF_I;
      ST_HALF_I: begin
        op_valid = 1'b1;
        op_a     = r_half;
        op_b     = r_t;
        if (op_ready) w_next = ST_HALF_W;
      end
      ST_HALF_W: if (res_valid) w_next = ST_SUB_I;
      ST_SUB_I: begin
        op_valid = 1'b1;
        op_sel   = 1'b1;
        op_a     = THREE_HALVES;
        op_b     = r_t;
        if (op_ready) w_next = ST_SUB_W;
      end
      ST_SUB_W:  if (res_valid) w_next = ST_UPD_I;
      ST_UPD_I: begin
        op_valid = 1'b1;
        op_a     = r_y;
        op_b     = r_t;
        if (op_ready) w_next = ST_UPD_W;
      end
      ST_UPD_W:  if (res_valid) w_next = w_last ? ST_DONE : ST_SQ_I;
      ST_DONE:   if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // in_ready is registered so it stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_t        <= '0;
      r_half     <= '0;
      r_iter     <= '0;
      r_special  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_accept) r_x <= in_data;
        ST_INIT: begin
          r_y       <= w_spec ? w_spec_val : MAGIC - (r_x >> 1);
          r_half    <= w_half;
          r_special <= w_spec;
          r_iter    <= '0;
        end
        ST_SQ_W, ST_HALF_W, ST_SUB_W: if (res_valid) r_t <= res_data;
        ST_UPD_W: begin
          if (res_valid) begin
            r_y    <= res_data;
            r_iter <= r_iter + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state == ST_DONE);
  assign out_data    = out_valid ? r_y : '0;
  assign out_special = out_valid && r_special;

endmodule
